// File: rtl/mem_arb_pkg.sv
// Shared encodings for mem_port_arbiter: FSM states, fixed fetch-side request
// fields and the data value returned for an aborted access.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  localparam logic        FETCH_WE   = 1'b0;
  localparam logic [3:0]  FETCH_BE   = 4'hF;
  localparam logic [31:0] ABORT_DATA = 32'h0000_0000;

  // Saturating increment of the fairness counter.
  function automatic logic [3:0] fair_inc(input logic [3:0] cnt, input logic [3:0] limit);
    return (cnt >= limit) ? limit : cnt + 4'd1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals of mem_port_arbiter.
// slave = arbiter view, master = requester/memory environment view.
interface mem_port_arbiter_if;

  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        if_stall;

  logic        me_req;
  logic        me_we;
  logic [3:0]  me_be;
  logic [31:0] me_addr;
  logic [31:0] me_wdata;
  logic [31:0] me_rdata;
  logic        me_ready;
  logic        me_stall;

  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  logic        err;

  modport slave (
    input  if_req, if_addr,
    input  me_req, me_we, me_be, me_addr, me_wdata,
    input  mem_rdata, mem_ack,
    output if_rdata, if_ready, if_stall,
    output me_rdata, me_ready, me_stall,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output err
  );

  modport master (
    output if_req, if_addr,
    output me_req, me_we, me_be, me_addr, me_wdata,
    output mem_rdata, mem_ack,
    input  if_rdata, if_ready, if_stall,
    input  me_rdata, me_ready, me_stall,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  err
  );

endinterface

// File: rtl/mem_arb_watchdog.sv
// Counts cycles an access spends granted; flags a timeout on the TIMEOUT-th
// granted cycle without an acknowledge.
module mem_arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic active,
  input  logic ack,
  output logic timeout
);

  // Counter only has to reach TIMEOUT-1; leaving the grant clears it.
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = '0;
    if (active) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout = active && !ack && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between fetch and data requesters, data first
// with a fairness bound on fetch starvation. Optional watchdog: MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int FAIR_LIMIT = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              clock,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  if ((FAIR_LIMIT < 1) || (FAIR_LIMIT > 15)) begin : g_bad_fair_limit
    $error("mem_port_arbiter: FAIR_LIMIT must be in 1..15");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mem_port_arbiter: TIMEOUT must be at least 1");
  end

  localparam logic [3:0] FAIR_LIM = 4'(FAIR_LIMIT);

  arb_state_e  state_q,     state_d;
  logic [3:0]  fair_cnt_q,  fair_cnt_d;
  logic        mem_req_q,   mem_req_d;
  logic        mem_we_q,    mem_we_d;
  logic [3:0]  mem_be_q,    mem_be_d;
  logic [31:0] mem_addr_q,  mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] if_rdata_q,  if_rdata_d;
  logic [31:0] me_rdata_q,  me_rdata_d;
  logic        if_ready_q,  if_ready_d;
  logic        me_ready_q,  me_ready_d;

  logic        in_grant;
  logic        timeout;
  logic        complete;
  logic [31:0] resp_data;

  assign in_grant  = (state_q == GNT_I) || (state_q == GNT_D);
  assign complete  = in_grant && (bus.mem_ack || timeout);
  assign resp_data = bus.mem_ack ? bus.mem_rdata : ABORT_DATA;

`ifdef MEM_ARB_TIMEOUT_EN
  logic err_q, err_d;

  mem_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .active  (in_grant),
    .ack     (bus.mem_ack),
    .timeout (timeout)
  );

  assign err_d = err_q || timeout;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign timeout = 1'b0;
  assign bus.err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    fair_cnt_d  = fair_cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    me_rdata_d  = me_rdata_q;
    if_ready_d  = 1'b0;
    me_ready_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!bus.if_req) begin
          fair_cnt_d = 4'd0;
        end
        // Data wins unless fetch has waited out FAIR_LIMIT data grants.
        if (bus.me_req && !(bus.if_req && (fair_cnt_q == FAIR_LIM))) begin
          state_d     = GNT_D;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.me_we;
          mem_be_d    = bus.me_be;
          mem_addr_d  = bus.me_addr;
          mem_wdata_d = bus.me_wdata;
          if (bus.if_req) begin
            fair_cnt_d = fair_inc(fair_cnt_q, FAIR_LIM);
          end
        end else if (bus.if_req) begin
          state_d     = GNT_I;
          mem_req_d   = 1'b1;
          mem_we_d    = FETCH_WE;
          mem_be_d    = FETCH_BE;
          mem_addr_d  = bus.if_addr;
          mem_wdata_d = 32'h0000_0000;
          fair_cnt_d  = 4'd0;
        end
      end

      GNT_I, GNT_D: begin
        if (complete) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          if (state_q == GNT_I) begin
            if_rdata_d = resp_data;
            if_ready_d = 1'b1;
          end else begin
            me_rdata_d = resp_data;
            me_ready_d = 1'b1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      fair_cnt_q  <= 4'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'h0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      if_rdata_q  <= 32'h0;
      me_rdata_q  <= 32'h0;
      if_ready_q  <= 1'b0;
      me_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fair_cnt_q  <= fair_cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      me_rdata_q  <= me_rdata_d;
      if_ready_q  <= if_ready_d;
      me_ready_q  <= me_ready_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.me_rdata  = me_rdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.me_ready  = me_ready_q;
  assign bus.if_stall  = bus.if_req && !if_ready_q;
  assign bus.me_stall  = bus.me_req && !me_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small wait-state memory responder.
// Timeout scenario runs only when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .FAIR_LIMIT (4),
    .TIMEOUT    (8)
  ) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Memory responder: acks after mem_wait wait cycles unless hung.
  int          mem_wait = 0;
  logic        mem_hang = 1'b0;
  logic [31:0] mem_data = 32'h0;
  int          wait_cnt = 0;

  always @(posedge clock) begin
    if (bus.mem_req && !bus.mem_ack) wait_cnt <= wait_cnt + 1;
    else                             wait_cnt <= 0;
  end

  assign bus.mem_ack   = bus.mem_req && !mem_hang && (wait_cnt == mem_wait);
  assign bus.mem_rdata = mem_data;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    bus.if_req   = 1'b0;
    bus.if_addr  = 32'h0;
    bus.me_req   = 1'b0;
    bus.me_we    = 1'b0;
    bus.me_be    = 4'h0;
    bus.me_addr  = 32'h0;
    bus.me_wdata = 32'h0;

    // Reset state
    repeat (2) step();
    check("rst_mem_req",  bus.mem_req,  1'b0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_if_ready", bus.if_ready, 1'b0);
    check("rst_me_ready", bus.me_ready, 1'b0);
    check("rst_if_rdata", bus.if_rdata, 32'h0);
    check("rst_err",      bus.err,      1'b0);
    reset = 1'b0;
    repeat (2) step();

    // Fetch only, zero-wait memory
    mem_data    = 32'h2408_0005;
    bus.if_addr = 32'h0000_3000;
    bus.if_req  = 1'b1;
    step();
    check("f_c1_mem_req",  bus.mem_req,  1'b1);
    check("f_c1_mem_addr", bus.mem_addr, 32'h0000_3000);
    check("f_c1_mem_be",   bus.mem_be,   4'hF);
    check("f_c1_mem_we",   bus.mem_we,   1'b0);
    check("f_c1_if_ready", bus.if_ready, 1'b0);
    check("f_c1_if_stall", bus.if_stall, 1'b1);
    step();
    check("f_c2_if_ready", bus.if_ready, 1'b1);
    check("f_c2_if_rdata", bus.if_rdata, 32'h2408_0005);
    check("f_c2_mem_req",  bus.mem_req,  1'b0);
    check("f_c2_if_stall", bus.if_stall, 1'b0);
    bus.if_req = 1'b0;
    step();
    check("f_c3_if_ready", bus.if_ready, 1'b0);
    check("f_c3_mem_req",  bus.mem_req,  1'b0);
    repeat (2) step();

    // Simultaneous requests: store first, then fetch
    mem_data     = 32'h1111_2222;
    bus.if_addr  = 32'h0000_3004;
    bus.if_req   = 1'b1;
    bus.me_req   = 1'b1;
    bus.me_we    = 1'b1;
    bus.me_be    = 4'b0011;
    bus.me_addr  = 32'h0000_0010;
    bus.me_wdata = 32'hDEAD_BEEF;
    step();
    check("b_c1_mem_req",   bus.mem_req,   1'b1);
    check("b_c1_mem_we",    bus.mem_we,    1'b1);
    check("b_c1_mem_be",    bus.mem_be,    4'b0011);
    check("b_c1_mem_addr",  bus.mem_addr,  32'h0000_0010);
    check("b_c1_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    check("b_c1_if_stall",  bus.if_stall,  1'b1);
    check("b_c1_me_stall",  bus.me_stall,  1'b1);
    step();
    check("b_c2_me_ready",  bus.me_ready,  1'b1);
    check("b_c2_if_ready",  bus.if_ready,  1'b0);
    check("b_c2_me_rdata",  bus.me_rdata,  32'h1111_2222);
    check("b_c2_if_stall",  bus.if_stall,  1'b1);
    bus.me_req = 1'b0;
    bus.me_we  = 1'b0;
    step();
    check("b_c3_mem_req",   bus.mem_req,   1'b0);
    check("b_c3_if_stall",  bus.if_stall,  1'b1);
    mem_data = 32'h3333_4444;
    step();
    check("b_c4_mem_req",   bus.mem_req,   1'b1);
    check("b_c4_mem_addr",  bus.mem_addr,  32'h0000_3004);
    check("b_c4_mem_we",    bus.mem_we,    1'b0);
    check("b_c4_mem_be",    bus.mem_be,    4'hF);
    check("b_c4_if_stall",  bus.if_stall,  1'b1);
    step();
    check("b_c5_if_ready",  bus.if_ready,  1'b1);
    check("b_c5_if_rdata",  bus.if_rdata,  32'h3333_4444);
    check("b_c5_me_rdata",  bus.me_rdata,  32'h1111_2222);
    check("b_c5_if_stall",  bus.if_stall,  1'b0);
    bus.if_req = 1'b0;
    repeat (3) step();

    // Fairness: both held, expect D D D D I D
    mem_data    = 32'h5A5A_0001;
    bus.if_addr = 32'h0000_3008;
    bus.me_addr = 32'h0000_0040;
    bus.me_be   = 4'hF;
    bus.me_we   = 1'b0;
    bus.if_req  = 1'b1;
    bus.me_req  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("fair_g%0d_mem_addr", k), bus.mem_addr,
            (k == 4) ? 32'h0000_3008 : 32'h0000_0040);
      step();
      check($sformatf("fair_g%0d_if_ready", k), bus.if_ready, (k == 4) ? 1'b1 : 1'b0);
      check($sformatf("fair_g%0d_me_ready", k), bus.me_ready, (k == 4) ? 1'b0 : 1'b1);
      step();
    end
    bus.if_req = 1'b0;
    bus.me_req = 1'b0;
    repeat (2) step();
    check("fair_idle_mem_req", bus.mem_req, 1'b0);

    // Three wait cycles; request fields change mid-access
    mem_wait    = 3;
    mem_data    = 32'hCAFE_F00D;
    bus.me_addr = 32'h0000_0020;
    bus.me_we   = 1'b0;
    bus.me_req  = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      check($sformatf("w_c%0d_mem_req", c),  bus.mem_req,  1'b1);
      check($sformatf("w_c%0d_mem_addr", c), bus.mem_addr, 32'h0000_0020);
      check($sformatf("w_c%0d_me_ready", c), bus.me_ready, 1'b0);
      if (c == 2) begin
        bus.me_addr = 32'h0000_0099;
        bus.me_we   = 1'b1;
      end
    end
    step();
    check("w_c5_me_ready", bus.me_ready, 1'b1);
    check("w_c5_me_rdata", bus.me_rdata, 32'hCAFE_F00D);
    check("w_c5_mem_req",  bus.mem_req,  1'b0);
    check("w_c5_mem_we",   bus.mem_we,   1'b0);
    bus.me_req = 1'b0;
    bus.me_we  = 1'b0;
    mem_wait   = 0;
    repeat (2) step();

    // Reset while granted
    mem_hang    = 1'b1;
    mem_data    = 32'h5555_AAAA;
    bus.me_addr = 32'h0000_0050;
    bus.me_req  = 1'b1;
    step();
    check("r_c1_mem_req", bus.mem_req, 1'b1);
    step();
    reset = 1'b1;
    #1;
    check("r_async_mem_req",  bus.mem_req,  1'b0);
    check("r_async_me_ready", bus.me_ready, 1'b0);
    step();
    check("r_hold_mem_req",   bus.mem_req,  1'b0);
    check("r_hold_me_ready",  bus.me_ready, 1'b0);
    mem_hang = 1'b0;
    reset    = 1'b0;
    step();
    check("r_reissue_mem_req",  bus.mem_req,  1'b1);
    check("r_reissue_mem_addr", bus.mem_addr, 32'h0000_0050);
    step();
    check("r_reissue_me_ready", bus.me_ready, 1'b1);
    check("r_reissue_me_rdata", bus.me_rdata, 32'h5555_AAAA);
    bus.me_req = 1'b0;
    repeat (2) step();

`ifdef MEM_ARB_TIMEOUT_EN
    // Watchdog abort after 8 granted cycles
    mem_hang    = 1'b1;
    mem_data    = 32'hFFFF_FFFF;
    bus.me_addr = 32'h0000_0060;
    bus.me_req  = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      check($sformatf("t_c%0d_mem_req", c), bus.mem_req, 1'b1);
      check($sformatf("t_c%0d_err", c),     bus.err,     1'b0);
    end
    step();
    check("t_c9_mem_req",  bus.mem_req,  1'b0);
    check("t_c9_me_ready", bus.me_ready, 1'b1);
    check("t_c9_me_rdata", bus.me_rdata, 32'h0);
    check("t_c9_err",      bus.err,      1'b1);
    bus.me_req = 1'b0;
    mem_hang   = 1'b0;
    repeat (3) step();
    check("t_sticky_err", bus.err, 1'b1);
    reset = 1'b1;
    step();
    check("t_reset_err", bus.err, 1'b0);
    reset = 1'b0;
    repeat (2) step();
`else
    check("no_timeout_err", bus.err, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
